// File: rtl/mv_job_ctrl.sv
// Job sequencer for the matrix-vector engine: accepts a descriptor,
// streams BRAM reads across rows, and flags init/acc/write per row.
module mv_job_ctrl #(
    parameter  int N          = 4,
    parameter  int DW         = 2,
    parameter  int BRAM_DEPTH = 32,
    parameter  int MAX_ROWS   = 8,
    parameter  int RD_LAT     = 1,
    localparam int AW         = $clog2(BRAM_DEPTH),
    localparam int RW         = $clog2(MAX_ROWS) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [AW-1:0] rd_base,
    input  logic [AW-1:0] wr_base,
    input  logic [RW-1:0] num_rows,
    input  logic          abort,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          init,
    output logic          acc_en,
    output logic          mem_wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          busy,
    output logic          done
);

    localparam int KW  = (N > 1) ? $clog2(N) : 1;
    localparam int DCW = $clog2(RD_LAT + 2);

    if (N < 1 || RD_LAT < 1 || DW < 1) begin : g_bad_param
        $error("mv_job_ctrl: N, RD_LAT and DW must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [KW-1:0]  k;
    logic [RW-1:0]  r;
    logic [RW-1:0]  rows;
    logic [RW-1:0]  rows_in;
    logic [DCW-1:0] dcnt;
    logic           accept;
    logic           flush;
    logic           k_last;
    logic           r_last;
    logic           rd_first;
    logic           rd_last;

    logic [RD_LAT-1:0] acc_p;
    logic [RD_LAT-1:0] ini_p;
    logic [RD_LAT:0]   wr_p;

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign rd_en       = (state == RUN);

    assign accept  = start_valid && start_ready;
    assign flush   = abort && busy;
    assign rows_in = (num_rows > RW'(MAX_ROWS)) ? RW'(MAX_ROWS) : num_rows;
    assign k_last  = (k == KW'(N - 1));
    assign r_last  = (r == rows - RW'(1));

    assign rd_first = rd_en && (k == '0);
    assign rd_last  = rd_en && k_last;

    assign acc_en    = acc_p[RD_LAT-1];
    assign init      = ini_p[RD_LAT-1];
    assign mem_wr_en = wr_p[RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = (num_rows == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (k_last && r_last) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (dcnt == DCW'(RD_LAT)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Reads are contiguous across rows, so the address simply counts up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= '0;
            r       <= '0;
            rows    <= '0;
            dcnt    <= '0;
            rd_addr <= '0;
            wr_addr <= '0;
        end else begin
            dcnt <= (state == DRAIN) ? dcnt + DCW'(1) : '0;
            if (rd_en) begin
                rd_addr <= rd_addr + AW'(1);
                if (k_last) begin
                    k <= '0;
                    r <= r + RW'(1);
                end else begin
                    k <= k + KW'(1);
                end
            end
            if (mem_wr_en) begin
                wr_addr <= wr_addr + AW'(1);
            end
            if (accept) begin
                k       <= '0;
                r       <= '0;
                rows    <= rows_in;
                rd_addr <= rd_base;
                wr_addr <= wr_base;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p <= '0;
            ini_p <= '0;
            wr_p  <= '0;
        end else if (flush) begin
            acc_p <= '0;
            ini_p <= '0;
            wr_p  <= '0;
        end else begin
            acc_p[0] <= rd_en;
            ini_p[0] <= rd_first;
            wr_p[0]  <= rd_last;
            for (int i = 1; i < RD_LAT; i++) begin
                acc_p[i] <= acc_p[i-1];
                ini_p[i] <= ini_p[i-1];
            end
            for (int i = 1; i <= RD_LAT; i++) begin
                wr_p[i] <= wr_p[i-1];
            end
        end
    end

endmodule

// File: doc/mv_job_ctrl.md
# mv_job_ctrl

Job sequencer for the matrix-vector engine. It accepts one job descriptor (read base, write base, row count) over a valid/ready handshake and then drives the engine for the whole job: BRAM read addresses, the per-row accumulator `init`, the element-valid `acc_en`, and one result write per row. Reads are streamed back-to-back across rows, and a `done` pulse closes the job. The block sits between the host/command logic and the BRAM plus MAC datapath, and replaces per-row manual start sequencing.

## Interface
- `N`, 4: elements per row (dot-product length); N ≥ 1.
- `DW`, 2: element width; used only to keep descriptor widths consistent with the datapath.
- `BRAM_DEPTH`, 32: BRAM words. Defines AW = $clog2(BRAM_DEPTH).
- `MAX_ROWS`, 8: maximum rows per job. Defines RW = $clog2(MAX_ROWS)+1.
- `RD_LAT`, 1: BRAM read latency in cycles; RD_LAT ≥ 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_valid`  in  1  job descriptor valid.
- `start_ready`  out  1  block can accept a job.
- `rd_base`  in  AW  address of row 0, element 0.
- `wr_base`  in  AW  result address of row 0.
- `num_rows`  in  RW  rows in the job, 0..MAX_ROWS.
- `abort`  in  1  synchronous job cancel.
- `rd_en`  out  1  BRAM read strobe.
- `rd_addr`  out  AW  BRAM read address.
- `init`  out  1  first element of a row is valid at the datapath this cycle.
- `acc_en`  out  1  an element is valid at the datapath this cycle.
- `mem_wr_en`  out  1  write accumulator result.
- `wr_addr`  out  AW  result write address.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle job-complete pulse.

## Operation
- States:
  - IDLE: `start_ready`=1.
  - RUN: issues reads.
  - DRAIN: flushes the pipeline.
  - DONE: one cycle, `done`=1.
- Accept on `start_valid && start_ready`. Descriptor fields are latched on acceptance; input changes after that are ignored.
  - IDLE→RUN if `num_rows` ≠ 0.
  - IDLE→DONE if `num_rows` = 0. No reads or writes are issued.
  - `num_rows` > MAX_ROWS is clamped to MAX_ROWS.
- RUN:
  - `rd_en`=1 every cycle for exactly N·R cycles (R = latched row count).
  - `rd_addr` = rd_base + r·N + k for row r, element k. Addresses wrap modulo 2^AW with no error.
  - The element counter k wraps N-1→0 and increments the row counter r. There are no gaps between rows.
  - After the last read, go to DRAIN.
- Pipeline flags delay `rd_en`, first-of-row and last-of-row:
  - `acc_en` = `rd_en` delayed RD_LAT.
  - `init` = first-of-row delayed RD_LAT.
  - `mem_wr_en` = last-of-row delayed RD_LAT+1.
- Writes:
  - `wr_addr` = wr_base at job start.
  - `wr_addr` increments by 1 (wrapping) on the cycle after each `mem_wr_en`.
  - `wr_addr` holds its value while `mem_wr_en` is 0.
- DRAIN lasts RD_LAT+1 cycles, then goes to DONE. DONE→IDLE.
- `busy`=1 in RUN, DRAIN and DONE.
- `abort` is sampled in any non-IDLE state:
  - The next state is IDLE.
  - All pipeline flags are cleared the same edge, so no later `acc_en`, `init` or `mem_wr_en` appears.
  - No `done` pulse.
  - `abort` in IDLE is ignored. `abort` together with an accept in IDLE: the accept wins.
- Reset values: `start_ready`=1. `rd_en`, `init`, `acc_en`, `mem_wr_en`, `busy`, `done` = 0. `rd_addr`, `wr_addr` = 0. State = IDLE with pipelines cleared.
- Async reset mid-job behaves identically to abort plus all outputs at reset values.

## Timing
- All outputs are registered.
- Cycle numbering: accept edge = cycle 0; outputs are named at the cycle they are high.
- Reads occupy cycles 1..N·R.
- `init` at cycles 1+RD_LAT+r·N.
- `acc_en` at cycles 1+RD_LAT .. N·R+RD_LAT.
- `mem_wr_en` for row r at cycle N·(r+1)+RD_LAT+1.
- `done` at cycle N·R+RD_LAT+2. `start_ready` returns the following cycle, so the back-to-back job issue interval is N·R+RD_LAT+3.
- `num_rows`=0: `done` at cycle 1, `start_ready` at cycle 2.
- Write cadence: `mem_wr_en` occurs one cycle after the last `acc_en` of a row. That is the same cycle as the next row's `init` when RD_LAT=1 and rows are consecutive. The datapath must latch the result before `init` clears the accumulator; write data is the pre-init value.

## Test plan
- N=4, RD_LAT=1, rd_base=0, wr_base=16, num_rows=2:
  - `rd_addr` 0..7 on cycles 1..8.
  - `init` on cycles 2 and 6; `acc_en` on cycles 2..9.
  - `mem_wr_en` on cycles 6 (`wr_addr`=16) and 10 (`wr_addr`=17).
  - `done` on cycle 11; `start_ready`=1 on cycle 12.
- num_rows=0 → no `rd_en`/`acc_en`/`mem_wr_en`; `done` on cycle 1; `busy` only on cycle 1.
- rd_base=30, num_rows=1, BRAM_DEPTH=32 → `rd_addr` sequence 30, 31, 0, 1. wr_base=31, num_rows=2 → writes at 31 then 0.
- `abort` at cycle 5 of the first scenario → IDLE at cycle 6. No `mem_wr_en` after cycle 5 and no `done`; a new job is accepted on cycle 6.
- `rst_n` low asynchronously at cycle 3 → all outputs at reset values immediately. After release, the next job behaves exactly as the first scenario.
- `start_valid` held high continuously with num_rows=1, N=4 → jobs are accepted every 8 cycles; descriptor changes during `busy` have no effect.
